serial_seq_detector: RTL and testbench

Moore-style sequence detector that consumes the registered serial bit stream produced by the team's D flip-flop stage (its `q` drives `bit_in`). It searches for the pattern 1011 on qualified bits. On each detection it emits a one-cycle `match` pulse and maintains a saturating detection count. It is the first decision stage after the serial capture flop in the FSM examples chain.

---
 rtl/serial_seq_detector_if.sv | 24 ++
 rtl/serial_seq_detector.sv | 72 +++++++
 tb/tb_serial_seq_detector.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_seq_detector_if.sv
// Serial bit-stream bus between the upstream capture flop (master) and the
// 1011 sequence detector (slave). The detector reports match/count/state back.
interface serial_seq_detector_if #(
    parameter int CNT_W = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic [2:0]       state_o;

    // Stream source: drives bits and the count clear, observes detections.
    modport master (
        output bit_in, bit_valid, clr,
        input  match, match_count, state_o
    );

    // Detector side.
    modport slave (
        input  bit_in, bit_valid, clr,
        output match, match_count, state_o
    );
endinterface

// File: rtl/serial_seq_detector.sv
// Moore detector for the pattern 1011 on qualified serial bits. Emits a
// registered one-cycle match pulse on entry to the detected state and keeps a
// saturating detection count with a synchronous clear.
module serial_seq_detector #(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_seq_detector_if.slave bus
);
    // Encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // nothing matched
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "101"
        S4 = 3'd4   // "1011" detected
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_enter_s4;
    logic             r_match;
    logic [CNT_W-1:0] r_count;

    // Next-state decode; state only advances on a qualified bit.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S0: if (bus.bit_valid) w_next_state = bus.bit_in ? S1 : S0;
            S1: if (bus.bit_valid) w_next_state = bus.bit_in ? S1 : S2;
            S2: if (bus.bit_valid) w_next_state = bus.bit_in ? S3 : S0;
            S3: if (bus.bit_valid) w_next_state = bus.bit_in ? S4 : S2;
            S4: if (bus.bit_valid) begin
                // Overlap keeps the trailing "1" of the match plus this "0" as "10".
                if (bus.bit_in)           w_next_state = S1;
                else if (OVERLAP != 0)    w_next_state = S2;
                else                      w_next_state = S0;
            end
            default: w_next_state = S0;  // illegal encodings recover unconditionally
        endcase
    end

    // Entering S4 is the only detection event; idling in S4 is not.
    assign w_enter_s4 = (r_state == S3) && bus.bit_valid && bus.bit_in;

    // State register, registered match pulse and saturating detection counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S0;
            r_match <= 1'b0;
            r_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
            r_match <= w_enter_s4;
            if (bus.clr) begin
                r_count <= '0;  // clear wins over a same-edge detection
            end else if (w_enter_s4 && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.match       = r_match;
    assign bus.match_count = r_count;
    assign bus.state_o     = r_state;
endmodule

// File: tb/tb_serial_seq_detector.sv
// Bench for serial_seq_detector. Three instances share one stimulus stream:
// overlap/8-bit count, non-overlap/8-bit count, non-overlap/2-bit count.
// A suffix-matching reference model predicts each edge's outputs into a
// scoreboard queue; a monitor pops one entry per edge and compares.
module tb_serial_seq_detector;
    localparam int N_DUT = 3;

    typedef struct packed {
        logic [2:0]      m;
        logic [2:0][7:0] c;
        logic [2:0][2:0] s;
    } exp_t;

    logic clk;
    logic rst_n;
    logic bit_in;
    logic bit_valid;
    logic clr;

    int n_cmp = 0;
    int n_mis = 0;
    int step_no = 0;

    exp_t sb[$];

    serial_seq_detector_if #(.CNT_W(8)) bus_a ();
    serial_seq_detector_if #(.CNT_W(8)) bus_b ();
    serial_seq_detector_if #(.CNT_W(2)) bus_c ();

    assign bus_a.bit_in = bit_in;  assign bus_a.bit_valid = bit_valid;  assign bus_a.clr = clr;
    assign bus_b.bit_in = bit_in;  assign bus_b.bit_valid = bit_valid;  assign bus_b.clr = clr;
    assign bus_c.bit_in = bit_in;  assign bus_c.bit_valid = bit_valid;  assign bus_c.clr = clr;

    serial_seq_detector #(.OVERLAP(1), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    serial_seq_detector #(.OVERLAP(0), .CNT_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    serial_seq_detector #(.OVERLAP(0), .CNT_W(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    wire [2:0]      act_m = {bus_c.match, bus_b.match, bus_a.match};
    wire [2:0][7:0] act_c = {{6'b0, bus_c.match_count}, bus_b.match_count, bus_a.match_count};
    wire [2:0][2:0] act_s = {bus_c.state_o, bus_b.state_o, bus_a.state_o};

    // Reference model: per instance, the last four valid bits and how many are meaningful.
    int m_ov   [N_DUT] = '{1, 0, 0};
    int m_max  [N_DUT] = '{255, 255, 3};
    int m_hist [N_DUT];
    int m_hlen [N_DUT];
    int m_cnt  [N_DUT];
    int m_st   [N_DUT];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", name, step_no, act, exp);
        end
    endtask

    // Longest suffix of the recent bits that is a prefix of 1011 (4 = full match).
    function automatic int prefix_len(input int h, input int l);
        for (int k = (l < 4 ? l : 4); k >= 1; k--) begin
            if ((h & ((1 << k) - 1)) == (11 >> (4 - k))) return k;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_DUT; i++) begin
            m_hist[i] = 0; m_hlen[i] = 0; m_cnt[i] = 0; m_st[i] = 0;
        end
    endfunction

    // Drive one edge's inputs and queue the outputs expected after that edge.
    task automatic step(input bit b, input bit v, input bit c, input bit rn);
        exp_t e;
        bit   det;
        @(negedge clk);
        step_no++;
        bit_in = b; bit_valid = v; clr = c; rst_n = rn;
        for (int i = 0; i < N_DUT; i++) begin
            det = 1'b0;
            if (!rn) begin
                m_hist[i] = 0; m_hlen[i] = 0; m_cnt[i] = 0; m_st[i] = 0;
            end else begin
                if (v) begin
                    m_hist[i] = ((m_hist[i] << 1) | int'(b)) & 15;
                    m_hlen[i] = (m_hlen[i] < 4) ? m_hlen[i] + 1 : 4;
                    det       = (m_hlen[i] == 4) && (m_hist[i] == 11);
                    m_st[i]   = prefix_len(m_hist[i], m_hlen[i]);
                    if (det && m_ov[i] == 0) m_hlen[i] = 0;  // search restarts
                end
                if (c)                              m_cnt[i] = 0;
                else if (det && m_cnt[i] < m_max[i]) m_cnt[i]++;
            end
            e.m[i] = det;
            e.c[i] = m_cnt[i][7:0];
            e.s[i] = m_st[i][2:0];
        end
        sb.push_back(e);
    endtask

    // Send n bits MSB-first with 'gap' idle edges after each bit.
    task automatic send(input logic [31:0] bits, input int n, input int gap);
        for (int j = n - 1; j >= 0; j--) begin
            step(bits[j], 1'b1, 1'b0, 1'b1);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bit_valid = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("async_rst.dut%0d.match", i), int'(act_m[i]), 0);
            check($sformatf("async_rst.dut%0d.count", i), int'(act_c[i]), 0);
            check($sformatf("async_rst.dut%0d.state", i), int'(act_s[i]), 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected snapshot per edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < N_DUT; i++) begin
                    check($sformatf("dut%0d.match", i), int'(act_m[i]), int'(e.m[i]));
                    check($sformatf("dut%0d.count", i), int'(act_c[i]), int'(e.c[i]));
                    check($sformatf("dut%0d.state", i), int'(act_s[i]), int'(e.s[i]));
                end
            end
        end
    end

    initial begin
        int r;
        rst_n = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clr = 1'b0;
        model_reset();

        // Reset state, then a single clean pattern.
        async_reset();
        idle(1);
        send(32'b1011, 4, 0);
        idle(2);

        // Overlapping stream 1011011.
        async_reset();
        send(32'b1011011, 7, 0);
        idle(2);

        // Idle gaps between pattern bits, then a long idle in S4.
        async_reset();
        send(32'b1011, 4, 3);
        idle(3);

        // Five separated detections (saturates the 2-bit counter), then
        // clear on the same edge as a sixth detection.
        async_reset();
        for (int k = 0; k < 5; k++) send(32'b101100, 6, 0);
        send(32'b101, 3, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Reset mid-pattern discards the partial 101.
        send(32'b101, 3, 0);
        async_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(2);

        // Randomised stream with occasional clears and resets.
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 999));
            step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 3), (r >= 5));
        end
        idle(2);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        #2;
        check("scoreboard_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
